// File: rtl/dut_seq_pkg.sv
// Shared types and default sizes for the vector sequencer.
// Optional feature macro: DUT_SEQ_INPUT_SYNC_EN adds a two-flop synchronizer on
// dut_in and stretches SETTLE by the two cycles the synchronizer adds.
package dut_seq_pkg;

  localparam int DUT_BUS_WIDTH = 32;
  localparam int ADDR_WIDTH    = 8;
  localparam int SETTLE_CYCLES = 2;

`ifdef DUT_SEQ_INPUT_SYNC_EN
  localparam int SYNC_EXTRA = 2;
`else
  localparam int SYNC_EXTRA = 0;
`endif

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_LOAD    = 3'd2,
    S_SETTLE  = 3'd3,
    S_CAPTURE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/dut_vector_sequencer_if.sv
// Vector buffer port between the sequencer (master) and the buffer RAM (slave).
// Handshake: there is no ready/backpressure. mem_rd_en is a one-cycle request and
// mem_rd_data is valid in the following cycle; mem_wr_en qualifies mem_wr_addr and
// mem_wr_data and the write is taken on the clock edge that ends the cycle.
// Read and write enables are never asserted together.
interface dut_vector_sequencer_if #(
  parameter int DW = dut_seq_pkg::DUT_BUS_WIDTH,
  parameter int AW = dut_seq_pkg::ADDR_WIDTH
);
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;

  modport master (
    output mem_rd_en, mem_rd_addr,
    input  mem_rd_data,
    output mem_wr_en, mem_wr_addr, mem_wr_data
  );

  modport slave (
    input  mem_rd_en, mem_rd_addr,
    output mem_rd_data,
    input  mem_wr_en, mem_wr_addr, mem_wr_data
  );
endinterface

// File: rtl/dut_vector_sequencer_in_sync.sv
// Two-flop synchronizer for the DUT sample bus; only instantiated when
// DUT_SEQ_INPUT_SYNC_EN is defined. Output lags the input by two clocks.
module dut_seq_in_sync #(
  parameter int WIDTH = dut_seq_pkg::DUT_BUS_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two-stage capture of the asynchronous DUT pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/dut_vector_sequencer.sv
// Vector sequencer: fetches each vector from the buffer, drives it onto the DUT
// pins, waits for the pins to settle, samples the DUT and writes the result back
// over the same buffer word. Per-vector period is 3 + settle length.
// Optional feature macro: DUT_SEQ_INPUT_SYNC_EN (synchronized dut_in, +2 settle).
module dut_vector_sequencer #(
  parameter int DUT_BUS_WIDTH = dut_seq_pkg::DUT_BUS_WIDTH,
  parameter int ADDR_WIDTH    = dut_seq_pkg::ADDR_WIDTH,
  parameter int SETTLE_CYCLES = dut_seq_pkg::SETTLE_CYCLES
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  input  logic                     go,
  input  logic [DUT_BUS_WIDTH-1:0] pin_dir,
  input  logic [ADDR_WIDTH:0]      burst_size,
  dut_vector_sequencer_if.master   mem,
  output logic [DUT_BUS_WIDTH-1:0] dut_out,
  output logic [DUT_BUS_WIDTH-1:0] dut_oe,
  input  logic [DUT_BUS_WIDTH-1:0] dut_in,
  output logic                     busy,
  output logic                     has_finished,
  output logic [ADDR_WIDTH:0]      vector_count,
  output dut_seq_pkg::state_t      dbg_state
);
  import dut_seq_pkg::*;

  localparam int SETTLE_LEN = SETTLE_CYCLES + SYNC_EXTRA;
  localparam int CW         = 5;
  localparam logic [CW-1:0]       SETTLE_LAST = CW'(SETTLE_LEN - 1);
  // Largest burst is one full pass over the buffer.
  localparam logic [ADDR_WIDTH:0] MAX_SIZE    = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                   state_q, state_d;
  logic [ADDR_WIDTH:0]      size_q, size_d;
  logic [ADDR_WIDTH:0]      count_q, count_d;
  logic [ADDR_WIDTH-1:0]    ptr_q, ptr_d;
  logic [DUT_BUS_WIDTH-1:0] pdir_q, pdir_d;
  logic [DUT_BUS_WIDTH-1:0] out_q, out_d;
  logic [DUT_BUS_WIDTH-1:0] oe_q, oe_d;
  logic [CW-1:0]            settle_q, settle_d;

  logic [DUT_BUS_WIDTH-1:0] dut_in_s;
  logic [ADDR_WIDTH:0]      size_clamped;
  logic [ADDR_WIDTH:0]      count_inc;
  logic                     rd_en, wr_en;
  logic [ADDR_WIDTH-1:0]    rd_addr, wr_addr;
  logic [DUT_BUS_WIDTH-1:0] wr_data;

`ifdef DUT_SEQ_INPUT_SYNC_EN
  dut_seq_in_sync #(.WIDTH(DUT_BUS_WIDTH)) u_in_sync (
    .clk   (ACLK),
    .rst_n (ARESETN),
    .d_i   (dut_in),
    .q_o   (dut_in_s)
  );
`else
  assign dut_in_s = dut_in;
`endif

  assign size_clamped = (burst_size > MAX_SIZE) ? MAX_SIZE : burst_size;
  assign count_inc    = count_q + 1'b1;

  // State and datapath registers; reset aborts any run without a write.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q  <= S_IDLE;
      size_q   <= '0;
      count_q  <= '0;
      ptr_q    <= '0;
      pdir_q   <= '0;
      out_q    <= '0;
      oe_q     <= '0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      size_q   <= size_d;
      count_q  <= count_d;
      ptr_q    <= ptr_d;
      pdir_q   <= pdir_d;
      out_q    <= out_d;
      oe_q     <= oe_d;
      settle_q <= settle_d;
    end
  end

  // Next-state and buffer-port decode. Dropping go aborts to IDLE from any busy
  // state; oe is cleared on every transition into IDLE or DONE.
  always_comb begin
    state_d  = state_q;
    size_d   = size_q;
    count_d  = count_q;
    ptr_d    = ptr_q;
    pdir_d   = pdir_q;
    out_d    = out_q;
    oe_d     = oe_q;
    settle_d = settle_q;
    rd_en    = 1'b0;
    rd_addr  = '0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    case (state_q)
      S_IDLE: begin
        oe_d = '0;
        if (go) begin
          size_d  = size_clamped;
          pdir_d  = pin_dir;
          count_d = '0;
          ptr_d   = '0;
          state_d = (size_clamped == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        rd_en   = 1'b1;
        rd_addr = ptr_q;
        if (go) begin
          state_d = S_LOAD;
        end else begin
          oe_d    = '0;
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (go) begin
          out_d    = mem.mem_rd_data;
          oe_d     = pdir_q;
          settle_d = '0;
          state_d  = S_SETTLE;
        end else begin
          oe_d    = '0;
          state_d = S_IDLE;
        end
      end
      S_SETTLE: begin
        if (!go) begin
          oe_d    = '0;
          state_d = S_IDLE;
        end else if (settle_q == SETTLE_LAST) begin
          state_d = S_CAPTURE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      S_CAPTURE: begin
        // The write is committed even if go drops in this cycle.
        wr_en   = 1'b1;
        wr_addr = ptr_q;
        wr_data = dut_in_s & ~pdir_q;
        count_d = count_inc;
        ptr_d   = ptr_q + 1'b1;
        if (!go) begin
          oe_d    = '0;
          state_d = S_IDLE;
        end else if (count_inc == size_q) begin
          oe_d    = '0;
          state_d = S_DONE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DONE: begin
        oe_d = '0;
        if (!go) state_d = S_IDLE;
      end
      default: begin
        oe_d    = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign mem.mem_rd_en   = rd_en;
  assign mem.mem_rd_addr = rd_addr;
  assign mem.mem_wr_en   = wr_en;
  assign mem.mem_wr_addr = wr_addr;
  assign mem.mem_wr_data = wr_data;

  assign dut_out      = out_q;
  assign dut_oe       = oe_q;
  assign vector_count = count_q;
  assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
  assign has_finished = (state_q == S_DONE);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_dut_vector_sequencer.sv
// Directed bench for dut_vector_sequencer: buffer RAM model, write scoreboard
// with an expected queue, period monitor and a final report.
`timescale 1ns/1ps
module tb_dut_vector_sequencer;
  import dut_seq_pkg::*;

  localparam int DW = 32;
  localparam int AW = 8;
`ifdef DUT_SEQ_INPUT_SYNC_EN
  localparam int SETTLE_LEN = 4;
`else
  localparam int SETTLE_LEN = 2;
`endif
  localparam int PERIOD = SETTLE_LEN + 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          go = 1'b0;
  logic [DW-1:0] pin_dir = '0;
  logic [AW:0]   burst_size = '0;
  logic [DW-1:0] dut_out, dut_oe, dut_in;
  logic          busy, has_finished;
  logic [AW:0]   vector_count;
  state_t        dbg_state;

  dut_vector_sequencer_if #(.DW(DW), .AW(AW)) mem_if ();

  dut_vector_sequencer dut (
    .ACLK         (clk),
    .ARESETN      (rst_n),
    .go           (go),
    .pin_dir      (pin_dir),
    .burst_size   (burst_size),
    .mem          (mem_if.master),
    .dut_out      (dut_out),
    .dut_oe       (dut_oe),
    .dut_in       (dut_in),
    .busy         (busy),
    .has_finished (has_finished),
    .vector_count (vector_count),
    .dbg_state    (dbg_state)
  );

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- buffer RAM model (1-cycle read latency) ----------------
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (mem_if.mem_rd_en) mem_if.mem_rd_data <= mem[mem_if.mem_rd_addr];
    if (mem_if.mem_wr_en) mem[mem_if.mem_wr_addr] = mem_if.mem_wr_data;
  end

  // ---------------- DUT pin model ----------------
  logic          loopback = 1'b1;
  logic [DW-1:0] din_drv = '0;
  logic [DW-1:0] din_old = '0;
  assign dut_in = loopback ? (dut_out << 1) : din_drv;

  // ---------------- scoreboard / monitors ----------------
  logic [AW+DW-1:0] exp_q[$];
  int       cyc = 0, wr_cnt = 0, rd_cnt = 0, gap_bad = 0, both_bad = 0, last_wr_cyc = 0;
  bit       have_last = 1'b0;
  bit       hist_mode = 1'b0;
  logic [AW-1:0] hist_addr = '0;
  logic [DW-1:0] hist_pdir = '0;

  always @(negedge clk) begin
    cyc++;
    if (mem_if.mem_rd_en) rd_cnt++;
    if (mem_if.mem_rd_en && mem_if.mem_wr_en) both_bad++;
    if (mem_if.mem_wr_en) begin
      wr_cnt++;
      if (have_last && (cyc - last_wr_cyc) != PERIOD) gap_bad++;
      have_last   = 1'b1;
      last_wr_cyc = cyc;
      if (hist_mode) begin
        chk("sync_wr_addr", mem_if.mem_wr_addr, hist_addr);
        chk("sync_wr_data", mem_if.mem_wr_data, din_old & ~hist_pdir);
        hist_addr++;
      end else begin
        chk("wr_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0)
          chk("wr_addr_data", {mem_if.mem_wr_addr, mem_if.mem_wr_data}, exp_q.pop_front());
      end
    end
    // Tester-driven pin pattern: a new value every cycle, history of two kept.
    din_old = din_drv;
    din_drv = {cyc[15:0], ~cyc[15:0]};
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_mem(input logic [DW-1:0] base);
    for (int i = 0; i < 256; i++) mem[i] = base + DW'(i);
  endtask

  task automatic wait_finished(input string tag, input int budget);
    for (int i = 0; i < budget && !has_finished; i++) @(negedge clk);
    chk(tag, has_finished, 1);
  endtask

  task automatic start_run(input logic [AW:0] size, input logic [DW-1:0] dir);
    burst_size = size;
    pin_dir    = dir;
    have_last  = 1'b0;
    go         = 1'b1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  int wr0, rd0, gb0, k;

  initial begin
    // Reset state
    wait_cycles(3);
    chk("rst_state", dbg_state, S_IDLE);
    chk("rst_busy", busy, 0);
    chk("rst_fin", has_finished, 0);
    chk("rst_count", vector_count, 0);
    chk("rst_oe", dut_oe, 0);
    chk("rst_out", dut_out, 0);
    chk("rst_rd_en", mem_if.mem_rd_en, 0);
    chk("rst_wr_en", mem_if.mem_wr_en, 0);
    rst_n = 1'b1;
    wait_cycles(2);

    // T1: full 256-vector loopback burst with mixed pin directions
    load_mem('0);
    for (int i = 0; i < 256; i++) exp_q.push_back({8'(i), (32'(i) * 2) & 32'hFF3FFF43});
    wr0 = wr_cnt;
    gb0 = gap_bad;
    start_run(9'd256, 32'h00C000BC);
    @(negedge clk);
    chk("t1_fetch_first", dbg_state, S_FETCH);
    chk("t1_rd_addr0", mem_if.mem_rd_addr, 0);
    wait_finished("t1_finish", 256 * PERIOD + 20);
    chk("t1_count", vector_count, 256);
    chk("t1_writes", wr_cnt - wr0, 256);
    chk("t1_period", gap_bad - gb0, 0);
    chk("t1_exp_left", exp_q.size(), 0);
    chk("t1_oe_done", dut_oe, 0);
    chk("t1_busy_done", busy, 0);
    chk("t1_out_hold", dut_out, 255);
    chk("t1_mem255", mem[255], (32'd255 * 2) & 32'hFF3FFF43);
    wait_cycles(3);
    chk("t1_hold_done", dbg_state, S_DONE);
    go = 1'b0;
    @(negedge clk);
    chk("t1_back_idle", dbg_state, S_IDLE);
    chk("t1_fin_clear", has_finished, 0);

    // T2: zero-length burst goes straight to DONE with no buffer traffic
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    start_run(9'd0, 32'h0);
    @(negedge clk);
    chk("t2_done_next", dbg_state, S_DONE);
    chk("t2_fin", has_finished, 1);
    chk("t2_busy", busy, 0);
    wait_cycles(4);
    chk("t2_no_rd", rd_cnt - rd0, 0);
    chk("t2_no_wr", wr_cnt - wr0, 0);
    go = 1'b0;
    @(negedge clk);
    chk("t2_idle", dbg_state, S_IDLE);

    // T3: go dropped in the second vector's SETTLE
    load_mem(32'h00120001);
    exp_q.push_back({8'd0, 32'h00240000});
    wr0 = wr_cnt;
    start_run(9'd3, 32'h0000FFFF);
    for (k = 0; k < 3 * PERIOD && (wr_cnt - wr0) < 1; k++) @(negedge clk);
    chk("t3_first_wr", wr_cnt - wr0, 1);
    for (k = 0; k < 2 * PERIOD && dbg_state != S_SETTLE; k++) @(negedge clk);
    chk("t3_in_settle", dbg_state, S_SETTLE);
    chk("t3_oe_settle", dut_oe, 32'h0000FFFF);
    chk("t3_out_settle", dut_out, 32'h00120002);
    go = 1'b0;
    @(negedge clk);
    chk("t3_idle", dbg_state, S_IDLE);
    chk("t3_oe", dut_oe, 0);
    chk("t3_fin", has_finished, 0);
    wait_cycles(10);
    chk("t3_one_write", wr_cnt - wr0, 1);
    chk("t3_exp_left", exp_q.size(), 0);
    chk("t3_count", vector_count, 1);

    // T4: reset during CAPTURE of vector 10, then a fresh run from address 0
    load_mem('0);
    for (int i = 0; i < 10; i++) exp_q.push_back({8'(i), 32'(i) * 2});
    wr0 = wr_cnt;
    start_run(9'd20, 32'h0);
    for (k = 0; k < 11 * PERIOD + 10 && !(dbg_state == S_FETCH && mem_if.mem_rd_addr == 8'd10); k++)
      @(negedge clk);
    chk("t4_reach_v10", mem_if.mem_rd_addr, 10);
    repeat (SETTLE_LEN + 1) @(negedge clk);
    @(posedge clk);
    #1;
    chk("t4_in_capture", dbg_state, S_CAPTURE);
    chk("t4_capture_addr", mem_if.mem_wr_addr, 10);
    rst_n = 1'b0;
    go    = 1'b0;
    #1;
    chk("t4_rst_state", dbg_state, S_IDLE);
    chk("t4_rst_wr_en", mem_if.mem_wr_en, 0);
    chk("t4_rst_wr_data", mem_if.mem_wr_data, 0);
    chk("t4_rst_rd_en", mem_if.mem_rd_en, 0);
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_count", vector_count, 0);
    chk("t4_rst_out", dut_out, 0);
    chk("t4_rst_oe", dut_oe, 0);
    wait_cycles(3);
    rst_n = 1'b1;
    rd0 = rd_cnt;
    wait_cycles(4);
    chk("t4_stay_idle", dbg_state, S_IDLE);
    chk("t4_no_rd_idle", rd_cnt - rd0, 0);
    chk("t4_writes", wr_cnt - wr0, 10);
    chk("t4_mem10_kept", mem[10], 10);
    chk("t4_exp_left", exp_q.size(), 0);
    load_mem(32'h100);
    exp_q.push_back({8'd0, 32'h200});
    exp_q.push_back({8'd1, 32'h202});
    start_run(9'd2, 32'h0);
    @(negedge clk);
    chk("t4_fresh_rd_en", mem_if.mem_rd_en, 1);
    chk("t4_fresh_addr0", mem_if.mem_rd_addr, 0);
    wait_finished("t4_fresh_finish", 2 * PERIOD + 10);
    chk("t4_fresh_count", vector_count, 2);
    chk("t4_fresh_exp_left", exp_q.size(), 0);
    go = 1'b0;
    @(negedge clk);

    // T5: oversize burst clamps to 256
    load_mem('0);
    for (int i = 0; i < 256; i++) exp_q.push_back({8'(i), 32'(i) * 2});
    wr0 = wr_cnt;
    start_run(9'd300, 32'h0);
    wait_finished("t5_finish", 256 * PERIOD + 20);
    chk("t5_count", vector_count, 256);
    chk("t5_writes", wr_cnt - wr0, 256);
    chk("t5_exp_left", exp_q.size(), 0);
    go = 1'b0;
    @(negedge clk);

`ifdef DUT_SEQ_INPUT_SYNC_EN
    // T6: synchronized input, capture reflects dut_in from two cycles earlier
    load_mem('0);
    loopback  = 1'b0;
    hist_pdir = 32'h0000000F;
    hist_addr = '0;
    hist_mode = 1'b1;
    wr0 = wr_cnt;
    gb0 = gap_bad;
    start_run(9'd4, 32'h0000000F);
    wait_finished("t6_finish", 4 * PERIOD + 10);
    chk("t6_count", vector_count, 4);
    chk("t6_writes", wr_cnt - wr0, 4);
    chk("t6_period", gap_bad - gb0, 0);
    go = 1'b0;
    @(negedge clk);
    hist_mode = 1'b0;
    loopback  = 1'b1;
`endif

    chk("rd_wr_overlap", both_bad, 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
